wake: RTL and testbench

Final stage of the keyword-spotting pipeline. It consumes the word-detector result (`wrd_wake_i` / `wrd_wake_valid_i`, after the debug mux) and qualifies detections by requiring N consecutive positive results. On qualification it drives a held wake interrupt level, a one-cycle pulse and a saturating event count, then enforces a cooldown window in which further detections are ignored. The outputs go to the SoC interrupt and GPIO logic.

---
 rtl/wake_pkg.sv | 15 +
 rtl/wake_timer.sv | 30 +++
 rtl/wake.sv | 137 +++++++++++++
 tb/tb_wake.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/wake_pkg.sv
// Shared types and defaults for the wake qualification stage.
package wake_pkg;

  localparam int COUNT_BW = 16;
  localparam int HITS_BW  = 4;

  localparam logic [7:0] WAKE_COUNT_MAX = 8'd255;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    HOLD     = 2'd1,
    COOLDOWN = 2'd2
  } state_t;

endpackage

// File: rtl/wake_timer.sv
// Loadable down-counter shared by the HOLD and COOLDOWN windows.
module wake_timer #(
  parameter int COUNT_BW = 16
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                load_i,
  input  logic [COUNT_BW-1:0] load_val_i,
  input  logic                clr_i,
  output logic                zero_o
);

  logic [COUNT_BW-1:0] count;

  // Clear beats load; the counter parks at zero until reloaded.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      count <= '0;
    end else if (clr_i) begin
      count <= '0;
    end else if (load_i) begin
      count <= load_val_i;
    end else if (count != '0) begin
      count <= count - COUNT_BW'(1);
    end
  end

  assign zero_o = (count == '0);

endmodule

// File: rtl/wake.sv
// Wake qualifier: N consecutive detector hits raise a held wake level,
// a one-cycle pulse and a saturating event count, then a cooldown.
//
// Handshake: wrd_wake_valid_i is a one-cycle strobe with no back-pressure;
// wrd_wake_i is meaningful only in a cycle where the strobe is high.
module wake #(
  parameter int COUNT_BW = wake_pkg::COUNT_BW,
  parameter int HITS_BW  = wake_pkg::HITS_BW
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                ctl_pipeline_en_i,
  input  logic                wrd_wake_i,
  input  logic                wrd_wake_valid_i,
  input  logic [HITS_BW-1:0]  cfg_hits_i,
  input  logic [COUNT_BW-1:0] cfg_hold_i,
  input  logic [COUNT_BW-1:0] cfg_cooldown_i,
  output logic                wake_o,
  output logic                wake_pulse_o,
  output logic [7:0]          wake_count_o,
  output logic [1:0]          state_o
);

  import wake_pkg::*;

  state_t              state, state_next;
  logic [HITS_BW-1:0]  hits, hits_next;
  logic                wake_next;
  logic                pulse_next;
  logic [7:0]          count_next;
  logic                tmr_load;
  logic [COUNT_BW-1:0] tmr_val;
  logic                tmr_clr;
  logic                tmr_zero;

  logic [HITS_BW:0]    hits_inc;
  logic [HITS_BW:0]    hits_thr;
  logic                qualify;
  logic [COUNT_BW-1:0] hold_load;

  assign hits_inc  = {1'b0, hits} + (HITS_BW+1)'(1);
  assign hits_thr  = (cfg_hits_i == '0) ? (HITS_BW+1)'(1) : {1'b0, cfg_hits_i};
  assign qualify   = (hits_inc >= hits_thr);
  assign hold_load = (cfg_hold_i == '0) ? '0 : cfg_hold_i - COUNT_BW'(1);

  always_comb begin
    state_next = state;
    hits_next  = hits;
    wake_next  = wake_o;
    pulse_next = 1'b0;
    count_next = wake_count_o;
    tmr_load   = 1'b0;
    tmr_val    = '0;
    tmr_clr    = 1'b0;

    if (!ctl_pipeline_en_i) begin
      state_next = IDLE;
      hits_next  = '0;
      wake_next  = 1'b0;
      tmr_clr    = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          wake_next = 1'b0;
          if (wrd_wake_valid_i) begin
            if (!wrd_wake_i) begin
              hits_next = '0;
            end else if (qualify) begin
              state_next = HOLD;
              hits_next  = '0;
              wake_next  = 1'b1;
              pulse_next = 1'b1;
              tmr_load   = 1'b1;
              tmr_val    = hold_load;
              if (wake_count_o != WAKE_COUNT_MAX) count_next = wake_count_o + 8'd1;
            end else begin
              hits_next = (&hits) ? hits : hits_inc[HITS_BW-1:0];
            end
          end
        end
        HOLD: begin
          wake_next = 1'b1;
          if (tmr_zero) begin
            wake_next = 1'b0;
            if (cfg_cooldown_i != '0) begin
              state_next = COOLDOWN;
              tmr_load   = 1'b1;
              tmr_val    = cfg_cooldown_i - COUNT_BW'(1);
            end else begin
              state_next = IDLE;
            end
          end
        end
        COOLDOWN: begin
          wake_next = 1'b0;
          hits_next = '0;
          if (tmr_zero) state_next = IDLE;
        end
        default: begin
          // Encoding 3 is unreachable; fall back to a clean idle.
          state_next = IDLE;
          hits_next  = '0;
          wake_next  = 1'b0;
          tmr_clr    = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state        <= IDLE;
      hits         <= '0;
      wake_o       <= 1'b0;
      wake_pulse_o <= 1'b0;
      wake_count_o <= 8'd0;
    end else begin
      state        <= state_next;
      hits         <= hits_next;
      wake_o       <= wake_next;
      wake_pulse_o <= pulse_next;
      wake_count_o <= count_next;
    end
  end

  wake_timer #(.COUNT_BW(COUNT_BW)) u_timer (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .clr_i      (tmr_clr),
    .zero_o     (tmr_zero)
  );

  assign state_o = state;

endmodule

// File: tb/tb_wake.sv
// Directed bench for the wake qualifier.
module tb_wake;

  logic        clk_i;
  logic        rst_n_i;
  logic        ctl_pipeline_en_i;
  logic        wrd_wake_i;
  logic        wrd_wake_valid_i;
  logic [3:0]  cfg_hits_i;
  logic [15:0] cfg_hold_i;
  logic [15:0] cfg_cooldown_i;
  logic        wake_o;
  logic        wake_pulse_o;
  logic [7:0]  wake_count_o;
  logic [1:0]  state_o;

  int n_vec;
  int n_err;
  int exp_count;

  wake #(.COUNT_BW(16), .HITS_BW(4)) dut (
    .clk_i             (clk_i),
    .rst_n_i           (rst_n_i),
    .ctl_pipeline_en_i (ctl_pipeline_en_i),
    .wrd_wake_i        (wrd_wake_i),
    .wrd_wake_valid_i  (wrd_wake_valid_i),
    .cfg_hits_i        (cfg_hits_i),
    .cfg_hold_i        (cfg_hold_i),
    .cfg_cooldown_i    (cfg_cooldown_i),
    .wake_o            (wake_o),
    .wake_pulse_o      (wake_pulse_o),
    .wake_count_o      (wake_count_o),
    .state_o           (state_o)
  );

  // Clock and reset
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Advance one edge and settle before sampling outputs.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // One-cycle detector strobe.
  task automatic strobe(input logic w);
    wrd_wake_valid_i = 1'b1;
    wrd_wake_i       = w;
    tick();
    wrd_wake_valid_i = 1'b0;
    wrd_wake_i       = 1'b0;
  endtask

  function automatic int sat_inc(input int c);
    return (c >= 255) ? 255 : c + 1;
  endfunction

  task automatic test_reset();
    rst_n_i = 1'b0;
    repeat (3) tick();
    n_vec++; if (wake_o !== 1'b0) begin n_err++; $display("FAIL reset_wake got=%b exp=0", wake_o); end
    n_vec++; if (wake_pulse_o !== 1'b0) begin n_err++; $display("FAIL reset_pulse got=%b exp=0", wake_pulse_o); end
    n_vec++; if (wake_count_o !== 8'd0) begin n_err++; $display("FAIL reset_count got=%0d exp=0", wake_count_o); end
    n_vec++; if (state_o !== 2'd0) begin n_err++; $display("FAIL reset_state got=%0d exp=0", state_o); end
    rst_n_i = 1'b1;
    tick();
    exp_count = 0;
  endtask

  task automatic test_basic();
    cfg_hits_i = 4'd3; cfg_hold_i = 16'd4; cfg_cooldown_i = 16'd0;
    wrd_wake_valid_i = 1'b1; wrd_wake_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_vec++; if (wake_o !== 1'b0) begin n_err++; $display("FAIL basic_early strobe=%0d got=%b exp=0", i, wake_o); end
    end
    tick();
    wrd_wake_valid_i = 1'b0;
    exp_count = sat_inc(exp_count);
    for (int i = 0; i < 4; i++) begin
      n_vec++; if (wake_o !== 1'b1) begin n_err++; $display("FAIL basic_hold cyc=%0d got=%b exp=1", i, wake_o); end
      n_vec++; if (wake_pulse_o !== (i == 0)) begin n_err++; $display("FAIL basic_pulse cyc=%0d got=%b exp=%b", i, wake_pulse_o, i == 0); end
      n_vec++; if (state_o !== 2'd1) begin n_err++; $display("FAIL basic_state cyc=%0d got=%0d exp=1", i, state_o); end
      tick();
    end
    n_vec++; if (wake_o !== 1'b0) begin n_err++; $display("FAIL basic_end got=%b exp=0", wake_o); end
    n_vec++; if (state_o !== 2'd0) begin n_err++; $display("FAIL basic_end_state got=%0d exp=0", state_o); end
    n_vec++; if (wake_count_o !== 8'(exp_count)) begin n_err++; $display("FAIL basic_count got=%0d exp=%0d", wake_count_o, exp_count); end
  endtask

  task automatic test_broken_run();
    logic [4:0] pat;
    cfg_hits_i = 4'd3; cfg_hold_i = 16'd4; cfg_cooldown_i = 16'd0;
    pat = 5'b11011;
    for (int i = 4; i >= 0; i--) begin
      strobe(pat[i]);
      n_vec++; if (wake_o !== 1'b0) begin n_err++; $display("FAIL broken_nowake idx=%0d got=%b exp=0", i, wake_o); end
    end
    strobe(1'b1);
    exp_count = sat_inc(exp_count);
    n_vec++; if (wake_o !== 1'b1) begin n_err++; $display("FAIL broken_wake got=%b exp=1", wake_o); end
    n_vec++; if (wake_count_o !== 8'(exp_count)) begin n_err++; $display("FAIL broken_count got=%0d exp=%0d", wake_count_o, exp_count); end
    repeat (4) tick();
    n_vec++; if (wake_o !== 1'b0) begin n_err++; $display("FAIL broken_end got=%b exp=0", wake_o); end
  endtask

  task automatic test_cooldown();
    int ph;
    logic [1:0] exp_st;
    cfg_hits_i = 4'd1; cfg_hold_i = 16'd2; cfg_cooldown_i = 16'd5;
    wrd_wake_valid_i = 1'b1; wrd_wake_i = 1'b1;
    // Period of H+C+1 = 8 edges: 2 HOLD, 5 COOLDOWN, 1 IDLE.
    for (int e = 0; e < 24; e++) begin
      tick();
      ph = e % 8;
      if (ph == 0) exp_count = sat_inc(exp_count);
      exp_st = (ph < 2) ? 2'd1 : (ph < 7) ? 2'd2 : 2'd0;
      n_vec++; if (wake_o !== (ph < 2)) begin n_err++; $display("FAIL cd_wake edge=%0d got=%b exp=%b", e, wake_o, ph < 2); end
      n_vec++; if (wake_pulse_o !== (ph == 0)) begin n_err++; $display("FAIL cd_pulse edge=%0d got=%b exp=%b", e, wake_pulse_o, ph == 0); end
      n_vec++; if (state_o !== exp_st) begin n_err++; $display("FAIL cd_state edge=%0d got=%0d exp=%0d", e, state_o, exp_st); end
      n_vec++; if (wake_count_o !== 8'(exp_count)) begin n_err++; $display("FAIL cd_count edge=%0d got=%0d exp=%0d", e, wake_count_o, exp_count); end
    end
    wrd_wake_valid_i = 1'b0;
    tick();
  endtask

  task automatic test_zero_cfg();
    cfg_hits_i = 4'd0; cfg_hold_i = 16'd0; cfg_cooldown_i = 16'd0;
    wrd_wake_valid_i = 1'b1; wrd_wake_i = 1'b1;
    tick();
    exp_count = sat_inc(exp_count);
    n_vec++; if (wake_o !== 1'b1) begin n_err++; $display("FAIL zero_wake got=%b exp=1", wake_o); end
    n_vec++; if (wake_pulse_o !== 1'b1) begin n_err++; $display("FAIL zero_pulse got=%b exp=1", wake_pulse_o); end
    tick();
    wrd_wake_valid_i = 1'b0;
    n_vec++; if (wake_o !== 1'b0) begin n_err++; $display("FAIL zero_exit got=%b exp=0", wake_o); end
    n_vec++; if (state_o !== 2'd0) begin n_err++; $display("FAIL zero_exit_state got=%0d exp=0", state_o); end
    tick();
    n_vec++; if (wake_o !== 1'b0) begin n_err++; $display("FAIL zero_ignored got=%b exp=0", wake_o); end
    n_vec++; if (wake_count_o !== 8'(exp_count)) begin n_err++; $display("FAIL zero_count got=%0d exp=%0d", wake_count_o, exp_count); end
  endtask

  task automatic test_back_to_back();
    cfg_hits_i = 4'd1; cfg_hold_i = 16'd1; cfg_cooldown_i = 16'd0;
    wrd_wake_valid_i = 1'b1; wrd_wake_i = 1'b1;
    for (int e = 0; e < 6; e++) begin
      tick();
      if (e % 2 == 0) exp_count = sat_inc(exp_count);
      n_vec++; if (wake_o !== (e % 2 == 0)) begin n_err++; $display("FAIL b2b_wake edge=%0d got=%b exp=%b", e, wake_o, e % 2 == 0); end
      n_vec++; if (wake_pulse_o !== (e % 2 == 0)) begin n_err++; $display("FAIL b2b_pulse edge=%0d got=%b exp=%b", e, wake_pulse_o, e % 2 == 0); end
    end
    wrd_wake_valid_i = 1'b0;
    n_vec++; if (wake_count_o !== 8'(exp_count)) begin n_err++; $display("FAIL b2b_count got=%0d exp=%0d", wake_count_o, exp_count); end
  endtask

  task automatic test_disable();
    cfg_hits_i = 4'd1; cfg_hold_i = 16'd100; cfg_cooldown_i = 16'd0;
    strobe(1'b1);
    exp_count = sat_inc(exp_count);
    repeat (9) tick();
    n_vec++; if (wake_o !== 1'b1) begin n_err++; $display("FAIL dis_hold10 got=%b exp=1", wake_o); end
    ctl_pipeline_en_i = 1'b0;
    tick();
    n_vec++; if (wake_o !== 1'b0) begin n_err++; $display("FAIL dis_wake got=%b exp=0", wake_o); end
    n_vec++; if (state_o !== 2'd0) begin n_err++; $display("FAIL dis_state got=%0d exp=0", state_o); end
    n_vec++; if (wake_count_o !== 8'(exp_count)) begin n_err++; $display("FAIL dis_count got=%0d exp=%0d", wake_count_o, exp_count); end
    strobe(1'b1);
    n_vec++; if (wake_o !== 1'b0) begin n_err++; $display("FAIL dis_ignored got=%b exp=0", wake_o); end
    ctl_pipeline_en_i = 1'b1;
    strobe(1'b1);
    exp_count = sat_inc(exp_count);
    n_vec++; if (wake_o !== 1'b1) begin n_err++; $display("FAIL dis_requal got=%b exp=1", wake_o); end
    n_vec++; if (wake_count_o !== 8'(exp_count)) begin n_err++; $display("FAIL dis_requal_count got=%0d exp=%0d", wake_count_o, exp_count); end
    ctl_pipeline_en_i = 1'b0; tick(); ctl_pipeline_en_i = 1'b1;
    // A disable must also discard partial hit progress.
    cfg_hits_i = 4'd2; cfg_hold_i = 16'd1;
    strobe(1'b1);
    ctl_pipeline_en_i = 1'b0; tick(); ctl_pipeline_en_i = 1'b1;
    strobe(1'b1);
    n_vec++; if (wake_o !== 1'b0) begin n_err++; $display("FAIL dis_hits_clr got=%b exp=0", wake_o); end
    strobe(1'b1);
    exp_count = sat_inc(exp_count);
    n_vec++; if (wake_o !== 1'b1) begin n_err++; $display("FAIL dis_hits_wake got=%b exp=1", wake_o); end
    tick();
  endtask

  task automatic test_saturation_reset();
    cfg_hits_i = 4'd1; cfg_hold_i = 16'd1; cfg_cooldown_i = 16'd0;
    wrd_wake_valid_i = 1'b1; wrd_wake_i = 1'b1;
    for (int e = 0; e < 520; e++) begin
      tick();
      if (e % 2 == 0) exp_count = sat_inc(exp_count);
    end
    wrd_wake_valid_i = 1'b0;
    n_vec++; if (wake_count_o !== 8'd255) begin n_err++; $display("FAIL sat_count got=%0d exp=255", wake_count_o); end
    n_vec++; if (wake_count_o !== 8'(exp_count)) begin n_err++; $display("FAIL sat_model got=%0d exp=%0d", wake_count_o, exp_count); end
    cfg_hold_i = 16'd50;
    strobe(1'b1);
    n_vec++; if (wake_pulse_o !== 1'b1) begin n_err++; $display("FAIL sat_pulse got=%b exp=1", wake_pulse_o); end
    n_vec++; if (wake_count_o !== 8'd255) begin n_err++; $display("FAIL sat_hold got=%0d exp=255", wake_count_o); end
    repeat (5) tick();
    rst_n_i = 1'b0;
    tick();
    n_vec++; if (wake_o !== 1'b0) begin n_err++; $display("FAIL rst_wake got=%b exp=0", wake_o); end
    n_vec++; if (wake_pulse_o !== 1'b0) begin n_err++; $display("FAIL rst_pulse got=%b exp=0", wake_pulse_o); end
    n_vec++; if (wake_count_o !== 8'd0) begin n_err++; $display("FAIL rst_count got=%0d exp=0", wake_count_o); end
    n_vec++; if (state_o !== 2'd0) begin n_err++; $display("FAIL rst_state got=%0d exp=0", state_o); end
    rst_n_i = 1'b1;
    tick();
    strobe(1'b1);
    n_vec++; if (wake_count_o !== 8'd1) begin n_err++; $display("FAIL rst_recount got=%0d exp=1", wake_count_o); end
  endtask

  initial begin
    n_vec = 0; n_err = 0; exp_count = 0;
    rst_n_i = 1'b0; ctl_pipeline_en_i = 1'b1;
    wrd_wake_i = 1'b0; wrd_wake_valid_i = 1'b0;
    cfg_hits_i = 4'd1; cfg_hold_i = 16'd1; cfg_cooldown_i = 16'd0;
    test_reset();
    test_basic();
    test_broken_run();
    test_cooldown();
    test_zero_cfg();
    test_back_to_back();
    test_disable();
    test_saturation_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
